// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants and FSM state type, used by the key schedule
// and the cipher round datapath.
package simon_pkg;

  localparam int WORD_W    = 16;
  localparam int KEY_WORDS = 4;
  localparam int ROUNDS    = 32;

  localparam logic [WORD_W-1:0] SIMON_C = 16'hFFFC;

  // z0 written with index 0 at the MSB so the literal reads like the published sequence
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic z0_bit(input logic [5:0] idx);
    return Z0[6'd61 - idx];
  endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Combinational Simon 32/64 key expansion step: k[i] from k[i-1], k[i-3],
// k[i-4] and the round's z0 bit.
module simon_key_expand
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] k_im1,
  input  logic [WORD_W-1:0] k_im3,
  input  logic [WORD_W-1:0] k_im4,
  input  logic              z_bit,
  output logic [WORD_W-1:0] k_i
);

  logic [WORD_W-1:0] tmp_a;
  logic [WORD_W-1:0] tmp_b;

  assign tmp_a = {k_im1[2:0], k_im1[WORD_W-1:3]} ^ k_im3;
  assign tmp_b = tmp_a ^ {tmp_a[0], tmp_a[WORD_W-1:1]};
  assign k_i   = SIMON_C ^ {{(WORD_W-1){1'b0}}, z_bit} ^ k_im4 ^ tmp_b;

endmodule

// File: rtl/key_gen.sv
// Simon 32/64 key schedule: expands a 64-bit key into 32 round keys, one per
// clock on round_key, with done marking k31.
module key_gen
  import simon_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          key,
  output logic [WORD_W-1:0]    round_key,
  output logic                 done
);

  state_t state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;

  // win_reg[0] is the key currently on round_key; win_reg[3] is the newest
  logic [KEY_WORDS-1:0][WORD_W-1:0] win_reg, win_next;
  logic [KEY_WORDS-1:0][WORD_W-1:0] key_words;
  logic [WORD_W-1:0]                new_word;
  logic                             z_bit;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key_words
      assign key_words[gi] = key[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // While win_reg[0] holds k[c], the word being generated is k[c+4]
  assign z_bit = z0_bit({1'b0, cnt_reg});

  simon_key_expand u_expand (
    .k_im1 (win_reg[3]),
    .k_im3 (win_reg[1]),
    .k_im4 (win_reg[0]),
    .z_bit (z_bit),
    .k_i   (new_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      win_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      win_reg   <= win_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    win_next   = win_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          win_next   = key_words;
          cnt_next   = '0;
          done_next  = 1'b0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        win_next = {new_word, win_reg[KEY_WORDS-1:1]};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'(ROUNDS - 2)) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign round_key = win_reg[0];
  assign done      = done_reg;

endmodule

// File: tb/tb_key_gen.sv
// Scoreboard bench for key_gen: expected (round_key, done) pairs are queued
// when start is driven and popped one per clock edge.
module tb_key_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] key;
  logic [15:0] round_key;
  logic        done;

  key_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .round_key (round_key),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rk;
    logic        dn;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_keys [32];
  logic [15:0] got_keys [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [61:0] Z0_TB = 62'b11111010001001010110000111001101111101000100101011000011100110;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] ror(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic void build_model(input logic [63:0] k);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) exp_keys[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(exp_keys[i-1], 3) ^ exp_keys[i-3];
      t = t ^ ror(t, 1);
      exp_keys[i] = 16'hFFFC ^ {15'd0, Z0_TB[65-i]} ^ exp_keys[i-4] ^ t;
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("round_key", 32'(round_key), 32'(e.rk));
      check("done", 32'(done), 32'(e.dn));
    end
  endtask

  // mid_start: cycle at which start is pulsed again; abort_at: cycle at which reset hits
  task automatic run_sched(input logic [63:0] k, input int mid_start, input bit chg_key,
                           input int abort_at, input int hold);
    build_model(k);
    for (int i = 0; i < 32; i++) sb.push_back('{rk: exp_keys[i], dn: (i == 31)});
    key   = k;
    start = 1'b1;
    tick();
    got_keys[0] = round_key;
    start = 1'b0;
    if (chg_key) key = '1;
    for (int c = 1; c < 32; c++) begin
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_rk", 32'(round_key), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (c == mid_start) start = 1'b1;
      tick();
      start = 1'b0;
      got_keys[c] = round_key;
    end
    for (int h = 0; h < hold; h++) begin
      sb.push_back('{rk: exp_keys[31], dn: 1'b1});
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    key   = '0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = ~start;
      check("rst_rk", 32'(round_key), 32'h0);
      check("rst_done", 32'(done), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rk: 16'h0, dn: 1'b0});
      tick();
    end

    // Published vector plus hold in DONE
    run_sched(64'h1918111009080100, -1, 1'b0, -1, 3);
    check("pub_k0", 32'(got_keys[0]), 32'h0100);
    check("pub_k1", 32'(got_keys[1]), 32'h0908);
    check("pub_k2", 32'(got_keys[2]), 32'h1110);
    check("pub_k3", 32'(got_keys[3]), 32'h1918);
    check("pub_k4", 32'(got_keys[4]), 32'h71C3);
    check("pub_k5", 32'(got_keys[5]), 32'hB649);

    // start pulsed during RUN is ignored
    run_sched({$urandom, $urandom}, 10, 1'b0, -1, 2);

    // key change after E0 has no effect; hold 0 so the next start is back-to-back
    run_sched({$urandom, $urandom}, -1, 1'b1, -1, 0);

    // Restart from DONE with key 0 on the first DONE edge
    run_sched(64'h0, -1, 1'b0, -1, 1);
    check("zero_k4", 32'(got_keys[4]), 32'hFFFD);

    // Reset mid-run, then a clean full schedule
    run_sched(64'h0123456789ABCDEF, -1, 1'b0, 15, 0);
    sb.push_back('{rk: 16'h0, dn: 1'b0});
    tick();
    run_sched(64'h0123456789ABCDEF, -1, 1'b0, -1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
